// File: rtl/apb_pkg.sv
// Shared types and constants for the APB4 command master and its wait counter.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_state_e;

   // Bit positions inside PPROT.
   localparam int PROT_PRIV  = 0;
   localparam int PROT_NSEC  = 1;
   localparam int PROT_INSTR = 2;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;
   localparam int APB_STRB_W = APB_DATA_W / 8;

   typedef struct packed {
      logic [APB_ADDR_W-1:0] addr;
      logic                  write;
      logic [APB_DATA_W-1:0] wdata;
      logic [APB_STRB_W-1:0] strb;
      logic [2:0]            prot;
   } apb_cmd_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

   // A zero limit still keeps a 1-bit register so the counter never has zero width.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS wait counter; expired_o flags the last allowed wait cycle.
module apb_timeout_cnt
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic pclk_i,
   input  logic preset_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int            W    = cnt_width(TIMEOUT_CYCLES);
   localparam logic [W-1:0]  LAST = (TIMEOUT_CYCLES == 0) ? '0 : W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: assigning the default first keeps this always_comb free of inferred latches.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge pclk_i) begin
      // NOTE: non-blocking assignments let every register see pre-edge values.
      if (!preset_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
   end else begin : g_timeout
      assign expired_o = (cnt_q == LAST);
   end

endmodule

// File: rtl/apb4_cmd_master.sv
// Valid/ready command stream to AMBA 4 APB bridge with per-transfer timeout.
module apb4_cmd_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,
   input  logic [2:0]            cmd_prot,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic [STRB_WIDTH-1:0] pstrb,
   output logic [2:0]            pprot,
   output logic                  psel,
   output logic                  penable,
   input  logic                  pready,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pslverr
);

   apb_state_e            state_q, state_d;
   logic                  cmd_ready_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic                  pwrite_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic [STRB_WIDTH-1:0] pstrb_q;
   logic [2:0]            pprot_q;
   logic                  psel_q, penable_q;
   logic                  rsp_valid_q, rsp_err_q, rsp_timeout_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;

   logic accept, expired, cnt_en;

   assign accept = cmd_valid & cmd_ready_q;
   assign cnt_en = (state_q == ACCESS) & ~pready;

   apb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .pclk_i     (pclk),
      .preset_n_i (preset_n),
      .clr_i      (accept),
      .en_i       (cnt_en),
      .expired_o  (expired)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (pready || expired) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         pprot_q       <= '0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= (state_d == IDLE);
         case (state_q)
            IDLE: begin
               if (accept) begin
                  // Reads drive zero data and strobes onto the bus.
                  paddr_q  <= cmd_addr;
                  pwrite_q <= cmd_write;
                  pwdata_q <= cmd_write ? cmd_wdata : '0;
                  pstrb_q  <= cmd_write ? cmd_wstrb : '0;
                  pprot_q  <= cmd_prot;
                  psel_q   <= 1'b1;
               end
            end
            SETUP: penable_q <= 1'b1;
            ACCESS: begin
               if (pready || expired) begin
                  // pready takes priority over a timeout landing on the same edge.
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_err_q     <= pready ? pslverr : 1'b1;
                  rsp_timeout_q <= ~pready;
                  rsp_rdata_q   <= (pready && !pwrite_q) ? prdata : '0;
               end
            end
            RESP: if (rsp_ready) rsp_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign paddr       = paddr_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign pstrb       = pstrb_q;
   assign pprot       = pprot_q;
   assign psel        = psel_q;
   assign penable     = penable_q;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Directed bench for apb4_cmd_master: vector table plus backpressure and reset corner cases.
module tb_apb4_cmd_master;

   logic        pclk = 1'b0;
   logic        preset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic [2:0]  cmd_prot;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr, pwdata, prdata;
   logic        pwrite, psel, penable, pready, pslverr;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;

   int tests = 0;
   int fails = 0;

   always #5 pclk = ~pclk;

   apb4_cmd_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .pclk        (pclk),
      .preset_n    (preset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_write   (cmd_write),
      .cmd_wdata   (cmd_wdata),
      .cmd_wstrb   (cmd_wstrb),
      .cmd_prot    (cmd_prot),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .paddr       (paddr),
      .pwrite      (pwrite),
      .pwdata      (pwdata),
      .pstrb       (pstrb),
      .pprot       (pprot),
      .psel        (psel),
      .penable     (penable),
      .pready      (pready),
      .prdata      (prdata),
      .pslverr     (pslverr)
   );

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;      // wait states before pready; large = never
      logic [31:0] rdata;
      logic        slverr;
      logic [31:0] exp_pwdata;
      logic [3:0]  exp_pstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_to;
      int          exp_lat;    // edges from accept to first rsp_valid
      int          exp_pen;    // cycles with penable high
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int n, acc, pen, psel_c, bad, k;
      cmd_addr  = v.addr;
      cmd_write = v.write;
      cmd_wdata = v.wdata;
      cmd_wstrb = v.strb;
      cmd_prot  = v.prot;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 10) begin
         tick();
         k++;
      end
      tick();
      cmd_valid = 1'b0;
      cmd_wdata = 32'h5555_5555;
      cmd_wstrb = 4'h0;
      n = 1; acc = 0; pen = 0; psel_c = 0; bad = 0;
      while (!rsp_valid && n < 20) begin
         if (psel) begin
            psel_c++;
            if ({paddr, pwrite, pwdata, pstrb, pprot} !==
                {v.addr, v.write, v.exp_pwdata, v.exp_pstrb, v.prot}) bad++;
         end
         if (penable) begin
            pen++;
            pready = (acc == v.waits);
            acc++;
         end else begin
            pready = 1'b0;
         end
         prdata  = v.rdata;
         pslverr = v.slverr;
         tick();
         n++;
      end
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h0;
      check($sformatf("v%0d_latency", idx), 64'(n), 64'(v.exp_lat));
      check($sformatf("v%0d_penable_cycles", idx), 64'(pen), 64'(v.exp_pen));
      check($sformatf("v%0d_psel_cycles", idx), 64'(psel_c), 64'(v.exp_pen + 1));
      check($sformatf("v%0d_apb_fields", idx), 64'(bad), 64'd0);
      check($sformatf("v%0d_resp_phase", idx), 64'({rsp_valid, psel, penable}), 64'(3'b100));
      check($sformatf("v%0d_rdata", idx), 64'(rsp_rdata), 64'(v.exp_rdata));
      check($sformatf("v%0d_err_to", idx), 64'({rsp_err, rsp_timeout}), 64'({v.exp_err, v.exp_to}));
      tick();
      check($sformatf("v%0d_after_hs", idx), 64'({rsp_valid, cmd_ready}), 64'(2'b01));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, k;
      logic [33:0] held;

      vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, 0, 32'h0, 1'b0,
                  32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, 3, 1};
      vecs[1] = '{1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b000, 3, 32'h12345678, 1'b0,
                  32'h0, 4'h0, 32'h12345678, 1'b0, 1'b0, 6, 4};
      vecs[2] = '{1'b1, 32'h24, 32'h0000A5A5, 4'h3, 3'b001, 1, 32'h0, 1'b1,
                  32'h0000A5A5, 4'h3, 32'h0, 1'b1, 1'b0, 4, 2};
      vecs[3] = '{1'b0, 32'h28, 32'h11111111, 4'hF, 3'b100, 99, 32'hFFFFFFFF, 1'b0,
                  32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 6, 4};
      vecs[4] = '{1'b0, 32'h2C, 32'h0, 4'h0, 3'b011, 0, 32'hA5A55A5A, 1'b1,
                  32'h0, 4'h0, 32'hA5A55A5A, 1'b1, 1'b0, 3, 1};
      vecs[5] = '{1'b1, 32'h30, 32'hCAFEF00D, 4'h9, 3'b111, 2, 32'h87654321, 1'b0,
                  32'hCAFEF00D, 4'h9, 32'h0, 1'b0, 1'b0, 5, 3};
      vecs[6] = '{1'b0, 32'h34, 32'hABCDEF01, 4'h6, 3'b010, 2, 32'h0BADF00D, 1'b0,
                  32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1'b0, 5, 3};

      preset_n  = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_write = 1'b0;
      cmd_wdata = '0;
      cmd_wstrb = '0;
      cmd_prot  = '0;
      rsp_ready = 1'b1;
      pready    = 1'b0;
      prdata    = '0;
      pslverr   = 1'b0;

      // Reset state and release timing.
      repeat (3) tick();
      check("rst_paddr", 64'(paddr), 64'd0);
      check("rst_pwdata", 64'(pwdata), 64'd0);
      check("rst_rdata", 64'(rsp_rdata), 64'd0);
      check("rst_ctrl", 64'({pwrite, pstrb, pprot, psel, penable, cmd_ready,
                             rsp_valid, rsp_err, rsp_timeout}), 64'd0);
      preset_n = 1'b1;
      check("rel_ready_low", 64'(cmd_ready), 64'd0);
      tick();
      check("rel_ready_high", 64'(cmd_ready), 64'd1);

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Response backpressure with a competing command held on the input.
      rsp_ready = 1'b0;
      cmd_addr  = 32'h40;
      cmd_write = 1'b0;
      cmd_prot  = 3'b000;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      k = 0;
      while (!rsp_valid && k < 10) begin
         pready  = penable;
         prdata  = 32'h600DCAFE;
         pslverr = 1'b1;
         tick();
         k++;
      end
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h0;
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      held = {rsp_rdata, rsp_err, rsp_timeout};
      check("bp_rsp_fields", 64'(held), 64'({32'h600DCAFE, 1'b1, 1'b0}));
      cmd_addr  = 32'h80;
      cmd_write = 1'b1;
      cmd_wdata = 32'h0F0F0F0F;
      cmd_wstrb = 4'hF;
      cmd_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if ({rsp_rdata, rsp_err, rsp_timeout} !== held) bad++;
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || psel !== 1'b0) bad++;
      end
      check("bp_stall_stable", 64'(bad), 64'd0);
      rsp_ready = 1'b1;
      tick();
      check("bp_handshake", 64'({rsp_valid, cmd_ready, psel}), 64'(3'b010));
      tick();
      cmd_valid = 1'b0;
      check("bp_next_accept", 64'({psel, penable, paddr}), 64'({1'b1, 1'b0, 32'h80}));
      tick();
      pready = 1'b1;
      tick();
      pready = 1'b0;
      check("bp_next_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({1'b1, 1'b0, 32'h0}));
      tick();

      // Reset while ACCESS is waiting on the slave.
      cmd_addr  = 32'h90;
      cmd_write = 1'b0;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 10) begin
         tick();
         k++;
      end
      tick();
      cmd_valid = 1'b0;
      tick();
      check("rstacc_in_access", 64'({psel, penable}), 64'(2'b11));
      preset_n = 1'b0;
      tick();
      check("rstacc_dropped", 64'({psel, penable, rsp_valid, cmd_ready}), 64'd0);
      tick();
      pready   = 1'b1;
      prdata   = 32'hBAD0BAD0;
      preset_n = 1'b1;
      tick();
      check("rstacc_release", 64'({cmd_ready, rsp_valid, psel}), 64'(3'b100));
      pready = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rsp_valid !== 1'b0 || psel !== 1'b0) bad++;
      end
      check("rstacc_no_stale", 64'(bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
